mem_access_unit: RTL and testbench

- MEM-stage data-memory access engine, directly downstream of the memory-control decode.
- Consumes the decoded memRead/memWrite/mode, the effective address and the store data.
- Drives a word-wide, variable-latency data bus with a req/ack handshake and stalls the pipeline until the access completes.
- Returns byte/word load data, sign- or zero-extended, to writeback.

---
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Word-wide data bus between the MEM-stage access unit and data memory.
// req/ack handshake; busRdata is meaningful only alongside busAck.
interface mem_access_unit_if;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busBe;
  logic [31:0] busRdata;
  logic        busAck;

  modport master (
    output busReq, busWe, busAddr, busWdata, busBe,
    input  busRdata, busAck
  );

  modport slave (
    input  busReq, busWe, busAddr, busWdata, busBe,
    output busRdata, busAck
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data access engine: req/ack bus, stall, load extension.
// Optional MISALIGN_EXC_EN: misaligned word access -> addrErr, no bus cycle.
`ifndef MEM_BYTE
`define MEM_BYTE 2'b00
`endif
`ifndef MEM_WORD
`define MEM_WORD 2'b10
`endif

module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  mode,
  input  logic        loadUnsigned,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        done,
  output logic        busErr,
`ifdef MISALIGN_EXC_EN
  output logic        addrErr,
`endif
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      nxt;
  logic [7:0]  cnt;
  logic        req;
  logic        isByteReq;
  logic        misal;
  logic        ackHit;
  logic        tmo;
  logic        rdLat;
  logic        byteLat;
  logic        unsLat;
  logic [1:0]  laneLat;
  logic [7:0]  laneByte;
  logic [31:0] extData;
  logic        we;
  logic [31:0] baddr;
  logic [31:0] wdata;
  logic [3:0]  be;

  assign req       = memRead | memWrite;
  assign isByteReq = (mode == `MEM_BYTE);

`ifdef MISALIGN_EXC_EN
  assign misal = !isByteReq && (addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  assign ackHit = (state == REQ) && bus.busAck;
  assign tmo    = (state == REQ) && !bus.busAck && (cnt == LAST);

  assign laneByte = bus.busRdata[{laneLat, 3'b000} +: 8];
  assign extData  = byteLat
                  ? {{24{laneByte[7] & ~unsLat}}, laneByte}
                  : bus.busRdata;

  assign stall        = req && (state != DONE);
  assign done         = (state == DONE);
  assign bus.busReq   = (state == REQ);
  assign bus.busWe    = we;
  assign bus.busAddr  = baddr;
  assign bus.busWdata = wdata;
  assign bus.busBe    = be;

  // State register; reset aborts any access and drops busReq at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state: ack or timeout ends REQ; DONE always lasts one cycle.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (req) nxt = misal ? DONE : REQ;
      end
      REQ: begin
        if (ackHit || tmo) nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Bus request latch on issue; byte stores replicate onto every lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we      <= 1'b0;
      baddr   <= '0;
      wdata   <= '0;
      be      <= '0;
      rdLat   <= 1'b0;
      byteLat <= 1'b0;
      unsLat  <= 1'b0;
      laneLat <= '0;
    end else if (state == IDLE && req && !misal) begin
      we      <= memWrite;
      baddr   <= {addr[31:2], 2'b00};
      rdLat   <= !memWrite;
      byteLat <= isByteReq;
      unsLat  <= loadUnsigned;
      laneLat <= addr[1:0];
      if (memWrite && isByteReq) begin
        be    <= 4'b0001 << addr[1:0];
        wdata <= {4{storeData[7:0]}};
      end else begin
        be    <= 4'b1111;
        wdata <= storeData;
      end
    end
  end

  // Completion: load capture on ack, zero result and error flag on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      loadData <= '0;
      busErr   <= 1'b0;
    end else begin
      busErr <= 1'b0;
      if (ackHit) begin
        cnt <= '0;
        if (rdLat) loadData <= extData;
      end else if (tmo) begin
        cnt      <= '0;
        loadData <= '0;
        busErr   <= 1'b1;
      end else if (state == REQ) begin
        cnt <= cnt + 8'd1;
      end else if (state == IDLE && req && misal) begin
        loadData <= '0;
      end
    end
  end

`ifdef MISALIGN_EXC_EN
  // Misaligned word access reports alongside its done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addrErr <= 1'b0;
    else        addrErr <= (state == IDLE) && req && misal;
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a load-result scoreboard.
// Bus responder is driven inline; TIMEOUT_CYCLES is set to 4.
module tb_mem_access_unit;

  localparam logic [1:0] MB = 2'b00;
  localparam logic [1:0] MW = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [1:0]  mode = MW;
  logic        loadUnsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] storeData = '0;
  logic        stall;
  logic [31:0] loadData;
  logic        done;
  logic        busErr;
  logic        aeObs;

  int checks = 0;
  int errors = 0;
  logic [31:0] expq[$];

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .memRead(memRead),
    .memWrite(memWrite),
    .mode(mode),
    .loadUnsigned(loadUnsigned),
    .addr(addr),
    .storeData(storeData),
    .stall(stall),
    .loadData(loadData),
    .done(done),
    .busErr(busErr),
`ifdef MISALIGN_EXC_EN
    .addrErr(aeObs),
`endif
    .bus(bus.master)
  );

`ifndef MISALIGN_EXC_EN
  assign aeObs = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic rd, input logic wr,
                     input logic [1:0] md, input logic uns,
                     input logic [31:0] a, input logic [31:0] sd,
                     input int ackAt, input logic [31:0] rdat,
                     input logic chkLoad, input logic [31:0] eLoad,
                     input logic [31:0] eAddr, input logic [3:0] eBe,
                     input logic eWe, input logic [31:0] eWd,
                     input logic eErr, input logic eAe,
                     input int eStall, input int eReq);
    int stalls;
    int reqs;
    bit seen;
    @(negedge clk);
    memRead = rd; memWrite = wr; mode = md;
    loadUnsigned = uns; addr = a; storeData = sd;
    bus.busAck = 1'b0;
    if (chkLoad) expq.push_back(eLoad);
    stalls = 0; reqs = 0; seen = 0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      #1;
      if (stall) stalls++;
      if (bus.busReq) begin
        reqs++;
        if (reqs == 1) begin
          chk({tag, ".addr"}, bus.busAddr, eAddr);
          chk({tag, ".be"}, {28'd0, bus.busBe}, {28'd0, eBe});
          chk({tag, ".we"}, {31'd0, bus.busWe}, {31'd0, eWe});
          if (eWe) chk({tag, ".wdata"}, bus.busWdata, eWd);
        end
        if (reqs == ackAt) begin
          bus.busAck = 1'b1;
          bus.busRdata = rdat;
        end
      end
      if (done) begin
        seen = 1;
        chk({tag, ".busErr"}, {31'd0, busErr}, {31'd0, eErr});
        chk({tag, ".addrErr"}, {31'd0, aeObs}, {31'd0, eAe});
        if (chkLoad) begin
          if (expq.size() == 0) chk({tag, ".sbEmpty"}, 32'd1, 32'd0);
          else chk({tag, ".load"}, loadData, expq.pop_front());
        end
      end
      @(negedge clk);
      bus.busAck = 1'b0;
      bus.busRdata = 32'h5A5A_5A5A;
    end
    memRead = 1'b0; memWrite = 1'b0;
    chk({tag, ".doneSeen"}, {31'd0, seen}, 32'd1);
    chk({tag, ".stallCycles"}, stalls, eStall);
    chk({tag, ".reqCycles"}, reqs, eReq);
    #1;
    chk({tag, ".doneOnce"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    bus.busAck = 1'b0;
    bus.busRdata = 32'h5A5A_5A5A;
    #12;
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.busReq", {31'd0, bus.busReq}, 32'd0);
    chk("rst.busBe", {28'd0, bus.busBe}, 32'd0);
    chk("rst.load", loadData, 32'd0);
    chk("rst.busErr", {31'd0, busErr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("lw", 1, 0, MW, 0, 32'h100, 0, 3, 32'hDEAD_BEEF,
        1, 32'hDEAD_BEEF, 32'h100, 4'hF, 0, 0, 0, 0, 4, 3);
    run("lb", 1, 0, MB, 0, 32'h103, 0, 1, 32'h80FF_0000,
        1, 32'hFFFF_FF80, 32'h100, 4'hF, 0, 0, 0, 0, 2, 1);
    run("lbu", 1, 0, MB, 1, 32'h103, 0, 1, 32'h80FF_0000,
        1, 32'h0000_0080, 32'h100, 4'hF, 0, 0, 0, 0, 2, 1);
    run("lbpos", 1, 0, MB, 0, 32'h101, 0, 2, 32'h1234_7F56,
        1, 32'h0000_007F, 32'h100, 4'hF, 0, 0, 0, 0, 3, 2);
    run("lbu0", 1, 0, MB, 1, 32'h108, 0, 1, 32'h0000_00FE,
        1, 32'h0000_00FE, 32'h108, 4'hF, 0, 0, 0, 0, 2, 1);
    run("sb", 0, 1, MB, 0, 32'h202, 32'h1234_56AB, 2, 0,
        0, 0, 32'h200, 4'b0100, 1, 32'hABAB_ABAB, 0, 0, 3, 2);
    run("sw", 0, 1, MW, 0, 32'h300, 32'hCAFE_F00D, 1, 0,
        0, 0, 32'h300, 4'hF, 1, 32'hCAFE_F00D, 0, 0, 2, 1);
    run("rdwr", 1, 1, MB, 0, 32'h311, 32'h0000_0042, 1, 0,
        0, 0, 32'h310, 4'b0010, 1, 32'h4242_4242, 0, 0, 2, 1);
    run("mode1", 1, 0, 2'b01, 0, 32'h104, 0, 1, 32'h8765_4321,
        1, 32'h8765_4321, 32'h104, 4'hF, 0, 0, 0, 0, 2, 1);
`ifdef MISALIGN_EXC_EN
    run("lwmis", 1, 0, MW, 0, 32'h101, 0, 1, 32'h1111_1111,
        1, 32'h0, 32'h0, 4'h0, 0, 0, 0, 1, 1, 0);
`else
    run("lwmis", 1, 0, MW, 0, 32'h105, 0, 1, 32'h1111_1111,
        1, 32'h1111_1111, 32'h104, 4'hF, 0, 0, 0, 0, 2, 1);
`endif
    run("tmo", 1, 0, MW, 0, 32'h400, 0, 0, 0,
        1, 32'h0, 32'h400, 4'hF, 0, 0, 1, 0, 5, 4);

    @(negedge clk);
    bus.busAck = 1'b1;
    bus.busRdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.busAck = 1'b0;
    #1;
    chk("strayAck.done", {31'd0, done}, 32'd0);
    chk("strayAck.req", {31'd0, bus.busReq}, 32'd0);
    chk("strayAck.load", loadData, 32'd0);

    @(negedge clk);
    memRead = 1'b1; mode = MW; addr = 32'h500;
    @(negedge clk);
    #1;
    chk("rstMid.reqUp", {31'd0, bus.busReq}, 32'd1);
    #2;
    rst_n = 1'b0;
    memRead = 1'b0;
    #1;
    chk("rstMid.reqDrop", {31'd0, bus.busReq}, 32'd0);
    chk("rstMid.stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    chk("rstMid.noDone", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstMid.noDone2", {31'd0, done}, 32'd0);
    run("swAfterRst", 0, 1, MW, 0, 32'h600, 32'h0BAD_F00D, 2, 0,
        0, 0, 32'h600, 4'hF, 1, 32'h0BAD_F00D, 0, 0, 3, 2);

    chk("sb.drained", expq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
